// File: rtl/spi_master.sv
// Single-frame SPI master (mode 0, MSB first): sends an AW-bit address then a DW-bit word, capturing the data phase from miso.
// Optional `done` strobe on frame completion is enabled by defining SPI_MASTER_DONE_EN.
module spi_master #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] tx,
  output logic [DW-1:0] rx,
  input  logic          en,
  output logic          ss,
  output logic          sclk,
  input  logic          miso,
  output logic          mosi
`ifdef SPI_MASTER_DONE_EN
  ,
  output logic          done
`endif
);

  localparam int FW = AW + DW;
  localparam int CW = (FW > 2) ? $clog2(FW) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(FW - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [FW-1:0]   sh_q, sh_d;
  logic [DW-1:0]   cap_q, cap_d;
  logic [DW-1:0]   rx_q, rx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ss_q, ss_d;
  logic            mosi_q, mosi_d;
  logic            done_q, done_d;

  // NOTE: every signal assigned in this block gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cap_d   = cap_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    ss_d    = ss_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          sh_d    = {addr, tx};
          mosi_d  = addr[AW-1];
          ss_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          ss_d   = 1'b1;
          mosi_d = 1'b0;
        end
      end

      SHIFT: begin
        if (!en) begin
          // Abort: the partially captured word never reaches rx.
          ss_d    = 1'b1;
          mosi_d  = 1'b0;
          state_d = IDLE;
        end else begin
          // miso still holds the bit of the period that just ended.
          cap_d = {cap_q[DW-2:0], miso};
          sh_d  = {sh_q[FW-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            rx_d    = cap_d;
            mosi_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            mosi_d = sh_q[FW-2];
          end
        end
      end

      DONE: begin
        // Stay selected until the sequencer drops en; this also blocks re-triggering.
        if (!en) begin
          ss_d    = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        ss_d    = 1'b1;
        mosi_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cap_q   <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      ss_q    <= 1'b1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cap_q   <= cap_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      ss_q    <= ss_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  // Gated clock: one pulse per clk period while shifting, rising mid-bit, falling as mosi advances.
  assign sclk = (state_q == SHIFT) & ~clk;
  assign rx   = rx_q;
  assign ss   = ss_q;
  assign mosi = mosi_q;

`ifdef SPI_MASTER_DONE_EN
  assign done = done_q;
`else
  logic unused_done;
  assign unused_done = done_q;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Randomized scoreboard bench for spi_master: frames are predicted from {addr,tx} and the slave word,
// and a monitor compares each frame when ss returns high.
module tb_spi_master;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int N  = AW + DW;

  logic          clk = 1'b0;
  logic          reset_b;
  logic [AW-1:0] addr;
  logic [DW-1:0] tx;
  logic [DW-1:0] rx;
  logic          en;
  logic          ss;
  logic          sclk;
  logic          miso;
  logic          mosi;
`ifdef SPI_MASTER_DONE_EN
  logic          done;
`endif

  always #5 clk = ~clk;

  spi_master #(.AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .addr    (addr),
    .tx      (tx),
    .rx      (rx),
    .en      (en),
    .ss      (ss),
    .sclk    (sclk),
    .miso    (miso),
    .mosi    (mosi)
`ifdef SPI_MASTER_DONE_EN
    ,
    .done    (done)
`endif
  );

  typedef struct {
    int            pulses;
    logic [N-1:0]  word;
    logic [DW-1:0] rx;
    int            dones;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model_rx = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // Slave: loopback, or presents address-phase ones then slave_data, changing on sclk rise.
  logic          loopback = 1'b1;
  logic [N-1:0]  slave_word = '0;
  logic          miso_s = 1'b0;
  int            slv_idx = 0;

  assign miso = loopback ? mosi : miso_s;

  always @(posedge sclk or posedge ss) begin
    if (ss) slv_idx = 0;
    else begin
      miso_s = (slv_idx < N) ? slave_word[N-1-slv_idx] : 1'b0;
      slv_idx++;
    end
  end

  int            total_pulses = 0;
  int            ss_viol = 0;
  logic [N-1:0]  bits_acc = '0;

  always @(posedge sclk) begin
    total_pulses++;
    bits_acc = {bits_acc[N-2:0], mosi};
    if (ss !== 1'b0) ss_viol++;
  end

  // Monitor: a frame is presented when ss returns high.
  logic          ss_prev = 1'b1;
  int            base = 0;
  int            dcnt = 0;

  initial begin : monitor
    exp_t         e;
    int           p;
    int           pp;
    logic [N-1:0] mask;
    logic [N-1:0] want;
    forever begin
      @(posedge clk);
      #1;
      if (ss_prev === 1'b1 && ss === 1'b0) begin
        base = total_pulses;
        dcnt = 0;
      end
`ifdef SPI_MASTER_DONE_EN
      if (done === 1'b1) dcnt++;
`endif
      if (ss_prev === 1'b0 && ss === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=frame required=none @%0t", $time);
        end else begin
          e    = exp_q.pop_front();
          p    = total_pulses - base;
          pp   = (p > N) ? N : p;
          mask = '0;
          for (int i = 0; i < pp; i++) mask[i] = 1'b1;
          want = e.word >> (N - pp);
          check("sclk_pulses", p, e.pulses);
          check("mosi_bits", 32'(bits_acc & mask), 32'(want));
          check("rx", 32'(rx), 32'(e.rx));
          check("mosi_idle", 32'(mosi), 32'(0));
`ifdef SPI_MASTER_DONE_EN
          check("done_pulses", dcnt, e.dones);
`endif
        end
      end
      ss_prev = ss;
    end
  end

  // One frame; en is sampled high on exactly `hold` posedges starting at the load edge.
  task automatic do_frame(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic lb,
                          input logic [DW-1:0] sdata, input int hold);
    exp_t e;
    bit   full;
    @(negedge clk);
    loopback   = lb;
    slave_word = {{AW{1'b1}}, sdata};
    addr       = a;
    tx         = d;
    en         = 1'b1;
    full       = (hold >= N + 1);
    e.pulses   = (hold > N) ? N : hold;
    e.word     = {a, d};
    if (full) model_rx = lb ? d : sdata;
    e.rx       = model_rx;
    e.dones    = full ? 1 : 0;
    exp_q.push_back(e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0) begin
        addr = AW'($urandom);
        tx   = DW'($urandom);
      end
    end
    en = 1'b0;
    @(posedge clk);
    #1;
    check("ss_after_en_low", 32'(ss), 32'(1));
  endtask

  task automatic do_reset_mid(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
    exp_t e;
    @(negedge clk);
    loopback = 1'b1;
    addr     = a;
    tx       = d;
    en       = 1'b1;
    model_rx = '0;
    e.pulses = hold;
    e.word   = {a, d};
    e.rx     = '0;
    e.dones  = 0;
    exp_q.push_back(e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset_b = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_ss", 32'(ss), 32'(1));
    check("midreset_mosi", 32'(mosi), 32'(0));
    check("midreset_rx", 32'(rx), 32'(0));
    @(negedge clk);
    #1;
    check("midreset_sclk", 32'(sclk), 32'(0));
    reset_b = 1'b1;
    en      = 1'b0;
  endtask

  initial begin : stimulus
    int hold;
    int pulses_before;
    reset_b = 1'b0;
    en      = 1'b1;
    addr    = 8'h5A;
    tx      = 16'hC3C3;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_ss", 32'(ss), 32'(1));
      check("reset_mosi", 32'(mosi), 32'(0));
      check("reset_rx", 32'(rx), 32'(0));
      @(negedge clk);
      #1;
      check("reset_sclk", 32'(sclk), 32'(0));
    end
    check("reset_no_pulses", total_pulses, 0);
    en      = 1'b0;
    reset_b = 1'b1;
    @(posedge clk);

    // Loopback write, then slave read, then abort after 10 pulses.
    do_frame(8'hAA, 16'hAAAB, 1'b1, 16'h0000, 25);
    do_frame(AW'($urandom), DW'($urandom), 1'b0, 16'h1234, 25);
    do_frame(AW'($urandom), DW'($urandom), 1'b0, 16'hBEEF, 10);
    check("abort_rx_kept", 32'(rx), 32'(16'h1234));

    // Held enable gives one frame; one low cycle then a fresh frame.
    pulses_before = total_pulses;
    do_frame(AW'($urandom), DW'($urandom), 1'b1, 16'h0000, 60);
    check("held_single_frame", total_pulses - pulses_before, N);
    do_frame(AW'($urandom), DW'($urandom), 1'b0, DW'($urandom), 25);

    for (int k = 0; k < 14; k++) begin
      if ($urandom_range(3) == 0) hold = $urandom_range(1, N - 1);
      else                         hold = $urandom_range(N + 1, N + 6);
      do_frame(AW'($urandom), DW'($urandom), 1'($urandom), DW'($urandom), hold);
    end

    do_reset_mid(AW'($urandom), DW'($urandom), 7);
    do_frame(AW'($urandom), DW'($urandom), 1'b0, DW'($urandom), 25);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("sclk_only_with_ss_low", ss_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
